clock_ctrl: RTL and testbench
=============================

# clock_ctrl

Sequencing and time-set controller for the MM:SS `clock` counter datapath. It does three jobs:
- Generates the 1 Hz count enable from the system clock.
- Debounces three board keys.
- Runs a RUN / SET_MIN / SET_SEC state machine that freezes the counter, edits minutes and seconds with wrap-around, and loads the edited time back into the counter.

It sits between the raw board keys and the counter, and also drives the digit-blink mask used by the seven-segment display stage.

## Interface
Parameters:
- TICK_DIV, 50_000_000, system clock cycles per count-enable pulse (≥2)
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable synchronised samples required to accept a key level change (≥1)
- BLINK_DIV, 12_500_000, clock cycles per blink phase toggle (≥1)

Ports:
- clk  in  1  system clock; one clock domain only
- reset  in  1  asynchronous, active-high reset
- key_mode_n  in  1  raw mode key, active-low, asynchronous to clk
- key_inc_n  in  1  raw increment key, active-low, asynchronous
- key_dec_n  in  1  raw decrement key, active-low, asynchronous
- cur_min  in  6  counter's current minutes, 0–59
- cur_sec  in  6  counter's current seconds, 0–59
- sec_tick  out  1  one-cycle count enable to the counter
- load  out  1  one-cycle strobe: counter takes load_min/load_sec
- load_min  out  6  minutes value to load
- load_sec  out  6  seconds value to load
- edit_active  out  1  high in SET_MIN or SET_SEC; the display shows load_min/load_sec instead of cur_*
- blink_mask  out  4  per-digit blank enable {hex3,hex2,hex1,hex0}; 1 = blank the digit
- mode  out  2  0 = RUN, 1 = SET_MIN, 2 = SET_SEC

## Operation
- Reset values: state RUN; all outputs 0; prescaler, blink counter and blink phase 0; edit registers 0; debouncers in the released state.
- Keys: each key passes through a 2-flop synchroniser and then a debouncer. A press pulse (one cycle) is emitted when the debounced level goes from released to pressed. Release produces no pulse.
- RUN:
  - The prescaler counts 0..TICK_DIV-1.
  - sec_tick = 1 in the cycle the prescaler equals TICK_DIV-1; the prescaler then wraps to 0.
  - mode press → SET_MIN. In the same cycle, capture load_min ← cur_min and load_sec ← cur_sec.
- SET_MIN:
  - sec_tick is held 0 and the prescaler is held at 0.
  - inc press: load_min wraps 59→0, otherwise +1.
  - dec press: load_min wraps 0→59, otherwise −1.
  - mode press → SET_SEC.
- SET_SEC:
  - Same inc/dec rules, applied to load_sec.
  - mode press → RUN, with load = 1 for exactly that transition cycle and the prescaler cleared to 0. The first sec_tick follows TICK_DIV cycles after RUN is entered.
- Simultaneous events:
  - mode press together with inc/dec press in the same cycle: mode wins and the edit is discarded.
  - inc and dec pressed in the same cycle: no change.
- blink_mask:
  - RUN: 0000.
  - SET_MIN: 1100 while the blink phase is 1, otherwise 0000.
  - SET_SEC: 0011 while the blink phase is 1, otherwise 0000.
  - The blink phase toggles every BLINK_DIV cycles in the edit states and is forced to 0 in RUN. It is cleared on every state entry, so the edited digits are visible immediately.
- Reset mid-edit: the controller returns to RUN immediately with no load pulse. The counter keeps its own value.
- Out-of-range cur_min/cur_sec (>59) captured into the edit registers: the next inc gives 0, the next dec gives 59.

## Timing
- Key latency: raw edge → press pulse = 2 (synchroniser) + DEBOUNCE_CYCLES + 1 cycles, provided the level is stable throughout.
- A glitch shorter than DEBOUNCE_CYCLES synchronised samples produces no pulse. Any sample at the old level restarts the stability count.
- The press pulse is registered. The state/edit update is visible on outputs 1 cycle after the pulse.
- load and load_min/load_sec are registered and valid together. load_* are stable from the load cycle until the next SET_MIN entry.
- sec_tick period in RUN is exactly TICK_DIV cycles, with no drift across mode changes other than the restart on RUN entry.

## Structure
- Shared package clock_pkg:
  - mode encodings MODE_RUN / MODE_SET_MIN / MODE_SET_SEC
  - MAX_MIN = 59, MAX_SEC = 59
  - time field width = 6
- Sub-module key_debounce (parameter DEBOUNCE_CYCLES), instantiated three times. It contains the synchroniser, the stability counter and the press-pulse generation.
- The top level contains the FSM, the prescaler, the blink counter and the edit registers.

## Test plan
Use TICK_DIV=4, DEBOUNCE_CYCLES=3, BLINK_DIV=8.

1. Reset then RUN → sec_tick pulses every 4 cycles, first pulse on the 4th cycle after reset release; blink_mask = 0000, mode = 0.
2. key_mode_n held low 10 cycles with cur_min=12, cur_sec=34 → one press pulse at cycle 6 after the edge; then mode = 1, load_min = 12, load_sec = 34, sec_tick stays 0.
3. In SET_MIN from load_min = 59, one inc press → 0; from load_min = 0, one dec press → 59. A 2-cycle low glitch on key_inc_n causes no change.
4. mode → SET_SEC, two inc presses, mode press → load_sec = 36; load = 1 for exactly 1 cycle with load_min=12, load_sec=36; mode = 0; next sec_tick 4 cycles later.
5. inc and dec pressed in the same cycle in SET_SEC → no change; mode and inc pressed in the same cycle → state advances, value unchanged.
6. Reset asserted in SET_MIN → mode = 0, blink_mask = 0000 and no load pulse, all asynchronously, before the next clk edge.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the MM:SS clock controller: mode encodings,
// field limits and the wrap-around edit helpers.
package clock_pkg;

  localparam int unsigned TIME_W = 6;

  typedef logic [TIME_W-1:0] time_t;
  typedef logic [1:0]        mode_t;

  localparam mode_t MODE_RUN     = 2'd0;
  localparam mode_t MODE_SET_MIN = 2'd1;
  localparam mode_t MODE_SET_SEC = 2'd2;

  localparam time_t MAX_MIN = 6'd59;
  localparam time_t MAX_SEC = 6'd59;

  // Anything at or above the limit (including garbage captured from the
  // counter) rolls over to 0.
  function automatic time_t wrap_inc(input time_t v, input time_t max);
    return (v >= max) ? '0 : v + 6'd1;
  endfunction

  // 0 and out-of-range values both land on the limit.
  function automatic time_t wrap_dec(input time_t v, input time_t max);
    return (v == '0 || v > max) ? max : v - 6'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw active-low key -> 2-flop synchroniser -> stability debouncer.
// Ports: clk, reset (async high), key_n (raw key), press (1-cycle pulse).
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic          prev_q;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // level_q is the accepted (debounced) level, 1 = released.
  // Any sample equal to the accepted level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // Registered one cycle after the accepted level falls.
    press_d = prev_q & ~level_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      prev_q  <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], key_n};
      level_q <= level_d;
      prev_q  <= level_q;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/clock_ctrl.sv
// RUN / SET_MIN / SET_SEC controller: 1 Hz enable, key debounce, time edit.
// Ports: clk, reset, key_*_n, cur_min/sec in; sec_tick, load, load_*, edit_active, blink_mask, mode out.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned BLINK_DIV       = 12_500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_mode_n,
  input  logic        key_inc_n,
  input  logic        key_dec_n,
  input  logic [5:0]  cur_min,
  input  logic [5:0]  cur_sec,
  output logic        sec_tick,
  output logic        load,
  output logic [5:0]  load_min,
  output logic [5:0]  load_sec,
  output logic        edit_active,
  output logic [3:0]  blink_mask,
  output logic [1:0]  mode
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic mode_p, inc_p, dec_p;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
    .clk(clk), .reset(reset), .key_n(key_mode_n), .press(mode_p)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_inc (
    .clk(clk), .reset(reset), .key_n(key_inc_n), .press(inc_p)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_dec (
    .clk(clk), .reset(reset), .key_n(key_dec_n), .press(dec_p)
  );

  mode_t          state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [BW-1:0]  bcnt_q, bcnt_d;
  logic           blink_q, blink_d;
  time_t          lmin_q, lmin_d;
  time_t          lsec_q, lsec_d;
  logic           load_q, load_d;
  logic           tick;

  assign tick = (state_q == MODE_RUN) && (presc_q == PRESC_LAST);

  // inc and dec together cancel; mode beats both.
  always_comb begin
    state_d = state_q;
    presc_d = '0;
    lmin_d  = lmin_q;
    lsec_d  = lsec_q;
    load_d  = 1'b0;
    unique case (state_q)
      MODE_RUN: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (mode_p) begin
          state_d = MODE_SET_MIN;
          lmin_d  = cur_min;
          lsec_d  = cur_sec;
          presc_d = '0;
        end
      end
      MODE_SET_MIN: begin
        if (mode_p) begin
          state_d = MODE_SET_SEC;
        end else if (inc_p && !dec_p) begin
          lmin_d = wrap_inc(lmin_q, MAX_MIN);
        end else if (dec_p && !inc_p) begin
          lmin_d = wrap_dec(lmin_q, MAX_MIN);
        end
      end
      MODE_SET_SEC: begin
        if (mode_p) begin
          state_d = MODE_RUN;
          load_d  = 1'b1;
        end else if (inc_p && !dec_p) begin
          lsec_d = wrap_inc(lsec_q, MAX_SEC);
        end else if (dec_p && !inc_p) begin
          lsec_d = wrap_dec(lsec_q, MAX_SEC);
        end
      end
      default: begin
        state_d = MODE_RUN;
      end
    endcase
  end

  // Phase restarts at 0 on every state change so edited digits show first.
  always_comb begin
    bcnt_d  = '0;
    blink_d = 1'b0;
    if (state_q != MODE_RUN && state_d == state_q) begin
      if (bcnt_q == BLINK_LAST) begin
        blink_d = ~blink_q;
      end else begin
        bcnt_d  = bcnt_q + BW'(1);
        blink_d = blink_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MODE_RUN;
      presc_q <= '0;
      bcnt_q  <= '0;
      blink_q <= 1'b0;
      lmin_q  <= '0;
      lsec_q  <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
      lmin_q  <= lmin_d;
      lsec_q  <= lsec_d;
      load_q  <= load_d;
    end
  end

  always_comb begin
    blink_mask = 4'b0000;
    if (blink_q) begin
      if (state_q == MODE_SET_MIN) blink_mask = 4'b1100;
      if (state_q == MODE_SET_SEC) blink_mask = 4'b0011;
    end
  end

  assign sec_tick    = tick;
  assign load        = load_q;
  assign load_min    = lmin_q;
  assign load_sec    = lsec_q;
  assign edit_active = (state_q != MODE_RUN);
  assign mode        = state_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl with small dividers.
// Table of key presses plus hand-written timing sequences.
module tb_clock_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_mode_n, key_inc_n, key_dec_n;
  logic [5:0] cur_min, cur_sec;
  logic       sec_tick, load, edit_active;
  logic [5:0] load_min, load_sec;
  logic [3:0] blink_mask;
  logic [1:0] mode;

  clock_ctrl #(
    .TICK_DIV(4), .DEBOUNCE_CYCLES(3), .BLINK_DIV(8)
  ) dut (
    .clk(clk), .reset(reset),
    .key_mode_n(key_mode_n), .key_inc_n(key_inc_n), .key_dec_n(key_dec_n),
    .cur_min(cur_min), .cur_sec(cur_sec),
    .sec_tick(sec_tick), .load(load),
    .load_min(load_min), .load_sec(load_sec),
    .edit_active(edit_active), .blink_mask(blink_mask), .mode(mode)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // keys: [2]=mode [1]=inc [0]=dec
  typedef struct {
    logic [2:0] keys;
    int         n;
    logic [5:0] cmin;
    logic [5:0] csec;
    logic [1:0] emode;
    logic [5:0] emin;
    logic [5:0] esec;
  } row_t;

  row_t rows[16];

  task automatic press(input logic [2:0] keys);
    key_mode_n = ~keys[2];
    key_inc_n  = ~keys[1];
    key_dec_n  = ~keys[0];
    repeat (10) @(negedge clk);
    key_mode_n = 1'b1;
    key_inc_n  = 1'b1;
    key_dec_n  = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      cur_min = rows[i].cmin;
      cur_sec = rows[i].csec;
      repeat (rows[i].n) press(rows[i].keys);
      chk($sformatf("row%0d_mode", i), mode, rows[i].emode);
      chk($sformatf("row%0d_min", i), load_min, rows[i].emin);
      chk($sformatf("row%0d_sec", i), load_sec, rows[i].esec);
    end
  endtask

  // Mode press entering an edit state: state changes 7 edges after the
  // raw edge, blink phase flips 8 and 16 cycles after entry.
  task automatic mode_seq(input logic [1:0] old_m, input logic [1:0] new_m,
                          input logic [3:0] mask, input logic [5:0] emin,
                          input logic [5:0] esec);
    key_mode_n = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 10) key_mode_n = 1'b1;
      chk($sformatf("ent%0d_mode_k%0d", new_m, k), mode,
          (k < 7) ? old_m : new_m);
      if (k >= 7) begin
        chk($sformatf("ent%0d_blink_k%0d", new_m, k), blink_mask,
            (k >= 15 && k < 23) ? mask : 4'b0000);
        chk($sformatf("ent%0d_tick_k%0d", new_m, k), sec_tick, 0);
        chk($sformatf("ent%0d_edit_k%0d", new_m, k), edit_active, 1);
      end
      if (k == 7) begin
        chk($sformatf("ent%0d_min", new_m), load_min, emin);
        chk($sformatf("ent%0d_sec", new_m), load_sec, esec);
      end
    end
  endtask

  initial begin
    rows[0]  = '{keys: 3'b001, n: 12, cmin: 12, csec: 34, emode: 1, emin: 0,  esec: 34};
    rows[1]  = '{keys: 3'b001, n: 1,  cmin: 12, csec: 34, emode: 1, emin: 59, esec: 34};
    rows[2]  = '{keys: 3'b010, n: 1,  cmin: 12, csec: 34, emode: 1, emin: 0,  esec: 34};
    rows[3]  = '{keys: 3'b001, n: 1,  cmin: 12, csec: 34, emode: 1, emin: 59, esec: 34};
    rows[4]  = '{keys: 3'b010, n: 1,  cmin: 12, csec: 34, emode: 1, emin: 0,  esec: 34};
    rows[5]  = '{keys: 3'b010, n: 12, cmin: 12, csec: 34, emode: 1, emin: 12, esec: 34};
    rows[6]  = '{keys: 3'b011, n: 1,  cmin: 12, csec: 34, emode: 1, emin: 12, esec: 34};
    rows[7]  = '{keys: 3'b010, n: 1,  cmin: 12, csec: 34, emode: 1, emin: 13, esec: 34};
    rows[8]  = '{keys: 3'b001, n: 1,  cmin: 12, csec: 34, emode: 1, emin: 12, esec: 34};
    rows[9]  = '{keys: 3'b010, n: 2,  cmin: 12, csec: 34, emode: 2, emin: 12, esec: 36};
    rows[10] = '{keys: 3'b011, n: 1,  cmin: 12, csec: 34, emode: 2, emin: 12, esec: 36};
    rows[11] = '{keys: 3'b100, n: 1,  cmin: 63, csec: 60, emode: 1, emin: 63, esec: 60};
    rows[12] = '{keys: 3'b010, n: 1,  cmin: 63, csec: 60, emode: 1, emin: 0,  esec: 60};
    rows[13] = '{keys: 3'b110, n: 1,  cmin: 63, csec: 60, emode: 2, emin: 0,  esec: 60};
    rows[14] = '{keys: 3'b001, n: 1,  cmin: 63, csec: 60, emode: 2, emin: 0,  esec: 59};
    rows[15] = '{keys: 3'b101, n: 1,  cmin: 63, csec: 60, emode: 0, emin: 0,  esec: 59};

    reset      = 1'b1;
    key_mode_n = 1'b1;
    key_inc_n  = 1'b1;
    key_dec_n  = 1'b1;
    cur_min    = 6'd12;
    cur_sec    = 6'd34;
    #1;
    chk("rst_mode", mode, 0);
    chk("rst_blink", blink_mask, 0);
    chk("rst_tick", sec_tick, 0);
    chk("rst_load", load, 0);
    chk("rst_min", load_min, 0);
    chk("rst_edit", edit_active, 0);

    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("run_tick_k%0d", k), sec_tick, (k % 4) == 3);
      chk($sformatf("run_blink_k%0d", k), blink_mask, 0);
      @(negedge clk);
    end

    // Latency: raw edge to state change = 6 + 1 edges.
    mode_seq(2'd0, 2'd1, 4'b1100, 6'd12, 6'd34);

    // Glitch of 2 samples must not register.
    key_inc_n = 1'b0;
    repeat (2) @(negedge clk);
    key_inc_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch_min", load_min, 12);
    chk("glitch_mode", mode, 1);

    run_rows(0, 8);
    mode_seq(2'd1, 2'd2, 4'b0011, 6'd12, 6'd34);
    run_rows(9, 10);

    // SET_SEC -> RUN: one-cycle load, tick 4th cycle of RUN.
    key_mode_n = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 10) key_mode_n = 1'b1;
      chk($sformatf("ld_load_k%0d", k), load, k == 7);
      chk($sformatf("ld_mode_k%0d", k), mode, (k < 7) ? 2 : 0);
      chk($sformatf("ld_tick_k%0d", k), sec_tick, k == 10);
      if (k == 7 || k == 12) begin
        chk($sformatf("ld_min_k%0d", k), load_min, 12);
        chk($sformatf("ld_sec_k%0d", k), load_sec, 36);
      end
    end
    repeat (10) @(negedge clk);

    run_rows(11, 15);

    cur_min = 6'd5;
    cur_sec = 6'd6;
    mode_seq(2'd0, 2'd1, 4'b1100, 6'd5, 6'd6);
    repeat (7) @(negedge clk);
    chk("pre_rst_blink", blink_mask, 4'b1100);
    chk("pre_rst_edit", edit_active, 1);

    // Asynchronous reset well before the next rising edge.
    #2;
    reset = 1'b1;
    #1;
    chk("arst_mode", mode, 0);
    chk("arst_blink", blink_mask, 0);
    chk("arst_load", load, 0);
    chk("arst_edit", edit_active, 0);
    chk("arst_min", load_min, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_load_k%0d", k), load, 0);
      chk($sformatf("post_rst_mode_k%0d", k), mode, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1, "timeout");
  end

endmodule
